// File: rtl/solve_position.sv
// Ball position integrator: on each frame tick, adds the latched velocity to a fixed-point
// accumulator, clamps it to the playfield and reports which walls the ball is pressing against.
module solve_position #(
    parameter logic [9:0]  X_MIN  = 10'd8,
    parameter logic [9:0]  X_MAX  = 10'd631,
    parameter logic [9:0]  Y_MIN  = 10'd8,
    parameter logic [9:0]  Y_MAX  = 10'd471,
    parameter logic [9:0]  X_INIT = 10'd320,
    parameter logic [9:0]  Y_INIT = 10'd240,
    parameter int unsigned FRAC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic signed [10:0] velocity_x,
    input  logic signed [10:0] velocity_y,
    output logic [9:0]         pos_x,
    output logic [9:0]         pos_y,
    output logic [3:0]         collision,
    output logic               busy,
    output logic               update_done
);

    localparam int unsigned AW = 10 + FRAC + 1;
    localparam int unsigned SW = AW + 1;

    localparam logic signed [SW-1:0] X_LO = SW'({X_MIN, {FRAC{1'b0}}});
    localparam logic signed [SW-1:0] X_HI = SW'({X_MAX, {FRAC{1'b0}}});
    localparam logic signed [SW-1:0] Y_LO = SW'({Y_MIN, {FRAC{1'b0}}});
    localparam logic signed [SW-1:0] Y_HI = SW'({Y_MAX, {FRAC{1'b0}}});
    localparam logic signed [AW-1:0] X_ACC_INIT = AW'({X_INIT, {FRAC{1'b0}}});
    localparam logic signed [AW-1:0] Y_ACC_INIT = AW'({Y_INIT, {FRAC{1'b0}}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_CLAMP,
        S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic signed [10:0]    vx_q, vx_d;
    logic signed [10:0]    vy_q, vy_d;
    logic signed [SW-1:0]  nx_q, nx_d;
    logic signed [SW-1:0]  ny_q, ny_d;
    logic signed [AW-1:0]  acc_x_q, acc_x_d;
    logic signed [AW-1:0]  acc_y_q, acc_y_d;
    logic [3:0]            coll_pend_q, coll_pend_d;
    logic [9:0]            pos_x_q, pos_x_d;
    logic [9:0]            pos_y_q, pos_y_d;
    logic [3:0]            collision_q, collision_d;
    logic                  busy_q, busy_d;
    logic                  update_done_q, update_done_d;

    // Returns {hit_min_wall, hit_max_wall, clamped_acc}; a wall only counts as hit while
    // the velocity points into it, so a ball resting on a wall with zero velocity is quiet.
    function automatic logic [AW+1:0] clamp_axis(
        input logic signed [SW-1:0] n,
        input logic signed [10:0]   v,
        input logic signed [SW-1:0] lo,
        input logic signed [SW-1:0] hi
    );
        logic signed [AW-1:0] acc;
        logic [1:0]           hit;
        acc = n[AW-1:0];
        hit = 2'b00;
        if (n >= hi && v > 11'sd0) begin
            acc = hi[AW-1:0];
            hit = 2'b01;
        end else if (n > hi) begin
            acc = hi[AW-1:0];
        end else if (n <= lo && v < 11'sd0) begin
            acc = lo[AW-1:0];
            hit = 2'b10;
        end else if (n < lo) begin
            acc = lo[AW-1:0];
        end
        return {hit, acc};
    endfunction

    always_comb begin
        state_d       = state_q;
        vx_d          = vx_q;
        vy_d          = vy_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        acc_x_d       = acc_x_q;
        acc_y_d       = acc_y_q;
        coll_pend_d   = coll_pend_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        collision_d   = collision_q;
        busy_d        = busy_q;
        update_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    vx_d    = velocity_x;
                    vy_d    = velocity_y;
                    busy_d  = 1'b1;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                nx_d    = {{(SW-AW){acc_x_q[AW-1]}}, acc_x_q} + {{(SW-11){vx_q[10]}}, vx_q};
                ny_d    = {{(SW-AW){acc_y_q[AW-1]}}, acc_y_q} + {{(SW-11){vy_q[10]}}, vy_q};
                state_d = S_CLAMP;
            end
            S_CLAMP: begin
                {coll_pend_d[1:0], acc_x_d} = clamp_axis(nx_q, vx_q, X_LO, X_HI);
                {coll_pend_d[3:2], acc_y_d} = clamp_axis(ny_q, vy_q, Y_LO, Y_HI);
                state_d = S_OUT;
            end
            S_OUT: begin
                pos_x_d       = 10'(acc_x_q >>> FRAC);
                pos_y_d       = 10'(acc_y_q >>> FRAC);
                collision_d   = coll_pend_q;
                update_done_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vx_q          <= '0;
            vy_q          <= '0;
            nx_q          <= '0;
            ny_q          <= '0;
            acc_x_q       <= X_ACC_INIT;
            acc_y_q       <= Y_ACC_INIT;
            coll_pend_q   <= '0;
            pos_x_q       <= X_INIT;
            pos_y_q       <= Y_INIT;
            collision_q   <= '0;
            busy_q        <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
            acc_x_q       <= acc_x_d;
            acc_y_q       <= acc_y_d;
            coll_pend_q   <= coll_pend_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            collision_q   <= collision_d;
            busy_q        <= busy_d;
            update_done_q <= update_done_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign collision   = collision_q;
    assign busy        = busy_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_solve_position.sv
// Self-checking bench for solve_position: constant vector table, wall/corner/reset sequences,
// and biased random velocities checked against an integer reference model.
module tb_solve_position;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [10:0] velocity_x;
    logic [10:0] velocity_y;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [3:0]  collision;
    logic        busy;
    logic        update_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: accumulators in 1/16 pixel units as plain integers.
    int m_ax, m_ay, m_px, m_py, m_coll;

    solve_position dut (
        .clk(clk), .rst(rst), .tick(tick),
        .velocity_x(velocity_x), .velocity_y(velocity_y),
        .pos_x(pos_x), .pos_y(pos_y), .collision(collision),
        .busy(busy), .update_done(update_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ax = 320 * 16; m_ay = 240 * 16;
        m_px = 320;      m_py = 240;
        m_coll = 0;
    endfunction

    // One axis: move, stop at the walls, flag a hit only when heading into the wall.
    function automatic void step_axis(input int acc, input int v, input int lo_px, input int hi_px,
                                      output int acc_out, output int hit_hi, output int hit_lo);
        int n, lo, hi;
        n = acc + v; lo = lo_px * 16; hi = hi_px * 16;
        hit_hi = 0; hit_lo = 0;
        if (n >= hi) begin
            acc_out = hi;
            hit_hi  = (v > 0) ? 1 : 0;
        end else if (n <= lo) begin
            acc_out = lo;
            hit_lo  = (v < 0) ? 1 : 0;
        end else begin
            acc_out = n;
        end
    endfunction

    function automatic void model_update(input int vx, input int vy);
        int ax, ay, xr, xl, yb, yt;
        step_axis(m_ax, vx, 8, 631, ax, xr, xl);
        step_axis(m_ay, vy, 8, 471, ay, yb, yt);
        m_ax = ax; m_ay = ay;
        m_px = m_ax / 16; m_py = m_ay / 16;
        m_coll = yt * 8 + yb * 4 + xl * 2 + xr;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Issues one tick, scrambles the velocity inputs afterwards, optionally holds tick
    // high into the busy window, then checks latency, busy, the single pulse and the result.
    task automatic do_tick(input int vx, input int vy, input bit extra);
        int first, pulses;
        @(negedge clk);
        velocity_x = vx[10:0];
        velocity_y = vy[10:0];
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = extra;
        velocity_x = 11'($urandom);
        velocity_y = 11'($urandom);
        model_update(vx, vy);
        first = 0; pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (k < 3) chk("busy_during_update", int'(busy), 1);
            if (update_done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        chk("update_done_latency", first, 3);
        chk("update_done_pulses", pulses, 1);
        chk("busy_after_update", int'(busy), 0);
        chk("pos_x_model", int'(pos_x), m_px);
        chk("pos_y_model", int'(pos_y), m_py);
        chk("collision_model", int'(collision), m_coll);
    endtask

    typedef struct {
        bit rst_first;
        int vx;
        int vy;
        int ex;
        int ey;
        int ec;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int   seen;

        rst = 1'b0; tick = 1'b0; velocity_x = '0; velocity_y = '0;

        // Integer step, then fractional negative x, then sub-pixel y accumulation.
        for (int i = 0; i < 5; i++)  tbl.push_back('{1'b0, 16, 0, 321 + i, 240, 0});
        for (int i = 0; i < 4; i++)  tbl.push_back('{(i == 0), -8, 0, (i < 2) ? 319 : 318, 240, 0});
        for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 0, 1, 318, (i == 15) ? 241 : 240, 0});

        do_reset();
        chk("reset_pos_x", int'(pos_x), 320);
        chk("reset_pos_y", int'(pos_y), 240);
        chk("reset_collision", int'(collision), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_update_done", int'(update_done), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (update_done || busy) seen++;
        end
        chk("idle_no_activity", seen, 0);
        chk("idle_pos_x", int'(pos_x), 320);
        chk("idle_pos_y", int'(pos_y), 240);

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            do_tick(tbl[i].vx, tbl[i].vy, 1'b0);
            chk("tbl_pos_x", int'(pos_x), tbl[i].ex);
            chk("tbl_pos_y", int'(pos_y), tbl[i].ey);
            chk("tbl_collision", int'(collision), tbl[i].ec);
        end

        // Right wall: 5120 + 50*100 crosses 631*16, then back off by 50.
        do_reset();
        repeat (50) do_tick(100, 0, 1'b0);
        chk("right_wall_pos_x", int'(pos_x), 631);
        chk("right_wall_collision", int'(collision), 4'b0001);
        do_tick(-50, 0, 1'b0);
        chk("right_release_pos_x", int'(pos_x), 627);
        chk("right_release_collision", int'(collision), 0);

        // Top-left corner, with a tick arriving during the busy window on the last step.
        do_reset();
        repeat (49) do_tick(-100, -100, 1'b0);
        do_tick(-100, -100, 1'b1);
        chk("corner_pos_x", int'(pos_x), 8);
        chk("corner_pos_y", int'(pos_y), 8);
        chk("corner_collision", int'(collision), 4'b1010);
        do_tick(0, 0, 1'b0);
        chk("rest_on_wall_collision", int'(collision), 0);
        chk("rest_on_wall_pos_x", int'(pos_x), 8);

        // Reset during the SUM cycle aborts the update.
        do_reset();
        do_tick(40, 40, 1'b0);
        @(negedge clk);
        velocity_x = 11'd16; velocity_y = 11'd0; tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_pos_x", int'(pos_x), 320);
        chk("midreset_pos_y", int'(pos_y), 240);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_collision", int'(collision), 0);
        seen = int'(update_done);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (update_done) seen++;
        end
        chk("midreset_no_pulse", seen, 0);
        model_reset();
        do_tick(16, 0, 1'b0);
        chk("after_midreset_pos_x", int'(pos_x), 321);

        // Biased random walk so walls and corners get hit; some ticks use out-of-range velocities.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int sx, sy;
            sx = ($urandom_range(1) == 0) ? 1 : -1;
            sy = ($urandom_range(1) == 0) ? 1 : -1;
            for (int n = 0; n < 35; n++) begin
                int vx, vy;
                case ($urandom_range(9))
                    0:       begin vx = int'($urandom_range(2047)) - 1024; vy = int'($urandom_range(2047)) - 1024; end
                    1:       begin vx = 0; vy = 0; end
                    2, 3:    begin vx = int'($urandom_range(200)) - 100; vy = int'($urandom_range(200)) - 100; end
                    default: begin vx = sx * int'($urandom_range(100)); vy = sy * int'($urandom_range(100)); end
                endcase
                do_tick(vx, vy, ($urandom_range(7) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
